fifo_sync_param: RTL and testbench
==================================

Name: fifo_sync_param

Overview:
Parametrised single-clock FIFO, the next generation of the team's 8-bit FIFO. Adds configurable width and depth, non-power-of-two depth, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It also adds synchronous flush. It sits between a producer and a consumer in the same SYSCLK domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, number of storage entries (>=2; need not be a power of two)
AF_TH, 3, ALMOST_FULL asserts when COUNT >= AF_TH (1..DEPTH)
AE_TH, 1, ALMOST_EMPTY asserts when COUNT <= AE_TH (0..DEPTH-1)
CNT_W, 3, width of COUNT; must satisfy 2^CNT_W > DEPTH

Ports:
SYSCLK  in  1  system clock; all state changes on its rising edge
RST_B  in  1  reset, asynchronous, active-low
WR_EN  in  1  write request
RD_EN  in  1  read request
FLUSH  in  1  synchronous clear of contents; takes priority over WR_EN and RD_EN
CLR_ERR  in  1  synchronous clear of OVERFLOW and UNDERFLOW
FIFO_IN  in  WIDTH  write data
FIFO_OUT  out  WIDTH  read data (registered)
FULL  out  1  COUNT == DEPTH
EMPTY  out  1  COUNT == 0
ALMOST_FULL  out  1  COUNT >= AF_TH
ALMOST_EMPTY  out  1  COUNT <= AE_TH
COUNT  out  CNT_W  current occupancy
OVERFLOW  out  1  sticky: a write was dropped
UNDERFLOW  out  1  sticky: a read was rejected

Behaviour:
- Reset (RST_B=0, immediate, no clock needed):
  - Write pointer, read pointer, COUNT, FIFO_OUT, OVERFLOW and UNDERFLOW all = 0.
  - EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0 (given AF_TH>=1).
  - Storage array is not reset.
- Per rising edge (RST_B=1), evaluated from pre-edge state:
  - rd_ok = RD_EN & ~EMPTY.
  - wr_ok = WR_EN & (~FULL | rd_ok). Write while full is accepted if a read is accepted in the same cycle.
- Write accepted: mem[wptr] <= FIFO_IN; wptr advances by one and wraps DEPTH-1 -> 0.
- Read accepted: FIFO_OUT <= mem[rptr]; rptr advances and wraps the same way.
- FIFO_OUT holds its last value when no read is accepted.
- Latency: a word written at edge N can be read by RD_EN sampled at edge N+1. It appears on FIFO_OUT after that edge. No fall-through.
- Read on EMPTY returns the oldest word only after a write has landed. Simultaneous WR_EN and RD_EN on EMPTY: write accepted, read rejected, UNDERFLOW set.
- COUNT update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither are accepted.
  - COUNT never exceeds DEPTH and never goes below 0.
- All flags are combinational decodes of registered COUNT, so they change only after a clock edge (or on reset).
- OVERFLOW is set when WR_EN & FULL & ~rd_ok. The data is dropped and the pointers are unchanged.
- UNDERFLOW is set when RD_EN & EMPTY. FIFO_OUT is unchanged.
- Error flags:
  - Both are sticky until CLR_ERR=1 at an edge.
  - If set and clear conditions coincide in the same cycle, set wins.
- FLUSH=1 at an edge:
  - Pointers and COUNT go to 0; FIFO_OUT and the error flags are kept.
  - WR_EN and RD_EN that cycle are ignored and raise no error flags.
- Reset asserted mid-operation discards all contents immediately. Outputs go to reset values within the same cycle.

Test Plan:
- Reset, then idle -> EMPTY=1, FULL=0, COUNT=0, FIFO_OUT=0, ALMOST_EMPTY=1, OVERFLOW=UNDERFLOW=0.
- Defaults, write 11,24,31,46 on four edges, then write 57 -> COUNT steps 1..4. ALMOST_FULL=1 at COUNT=3, FULL=1 at COUNT=4. The 57 is dropped, OVERFLOW=1, COUNT stays 4.
- From full (11,24,31,46), RD_EN and WR_EN=1 with FIFO_IN=57 for one edge -> FIFO_OUT=11, COUNT=4, OVERFLOW unchanged. Four further reads give 24,31,46,57, then EMPTY=1.
- Drain to empty, hold RD_EN for 2 more edges -> FIFO_OUT holds 57, UNDERFLOW=1. CLR_ERR pulse clears it, and OVERFLOW clears too.
- DEPTH=5, AF_TH=4, AE_TH=2: push/pop 12 words through with random gaps -> output order matches input, pointers wrap 4->0, flags track COUNT exactly.
- Write 3 words, assert FLUSH together with WR_EN=1 -> COUNT=0, EMPTY=1, FIFO_OUT unchanged, no error flag. Reset asserted mid-burst on a clock low phase -> outputs reset before the next edge.

Source files
------------

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags,
// sticky overflow/underflow errors and synchronous flush.
module fifo_sync_param #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AF_TH = 3,
    parameter int unsigned AE_TH = 1,
    parameter int unsigned CNT_W = 3
) (
    input  logic             SYSCLK,
    input  logic             RST_B,
    input  logic             WR_EN,
    input  logic             RD_EN,
    input  logic             FLUSH,
    input  logic             CLR_ERR,
    input  logic [WIDTH-1:0] FIFO_IN,
    output logic [WIDTH-1:0] FIFO_OUT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             ALMOST_FULL,
    output logic             ALMOST_EMPTY,
    output logic [CNT_W-1:0] COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int unsigned      PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_TH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] fifo_out_q, fifo_out_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_ok;
    logic             wr_ok;
    logic             mem_we;

    // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign rd_ok = RD_EN & ~EMPTY;
    assign wr_ok = WR_EN & (~FULL | rd_ok);

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        fifo_out_d = fifo_out_q;
        ovf_d      = ovf_q & ~CLR_ERR;
        unf_d      = unf_q & ~CLR_ERR;
        mem_we     = 1'b0;
        if (FLUSH) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Set terms OR in after the clear so a coincident set wins.
            ovf_d = ovf_d | (WR_EN & FULL & ~rd_ok);
            unf_d = unf_d | (RD_EN & EMPTY);
            if (wr_ok) begin
                mem_we = 1'b1;
                wptr_d = ptr_inc(wptr_q);
            end
            if (rd_ok) begin
                fifo_out_d = mem_q[rptr_q];
                rptr_d     = ptr_inc(rptr_q);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            fifo_out_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            fifo_out_q <= fifo_out_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge SYSCLK) begin
        if (mem_we) begin
            mem_q[wptr_q] <= FIFO_IN;
        end
    end

    assign FIFO_OUT     = fifo_out_q;
    assign COUNT        = count_q;
    assign FULL         = (count_q == CNT_FULL);
    assign EMPTY        = (count_q == '0);
    assign ALMOST_FULL  = (count_q >= CNT_AF);
    assign ALMOST_EMPTY = (count_q <= CNT_AE);
    assign OVERFLOW     = ovf_q;
    assign UNDERFLOW    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Scoreboarded bench for fifo_sync_param: a default instance (DEPTH=4) and a
// DEPTH=5 instance, driven one at a time against a queue-based reference model.
module tb_fifo_sync_param;

    localparam int unsigned W = 8;
    localparam int D0 = 4, AF0 = 3, AE0 = 1;
    localparam int D1 = 5, AF1 = 4, AE1 = 2;

    logic         clk = 1'b0;
    logic         rst_b;
    logic [1:0]   wr_en, rd_en, flush, clr_err;
    logic [W-1:0] din0, din1;
    wire  [W-1:0] dout0, dout1;
    wire  [2:0]   cnt0, cnt1;
    wire  [1:0]   full, empty, af, ae, ovf, unf;

    always #5 clk = ~clk;

    fifo_sync_param u_dut0 (
        .SYSCLK(clk), .RST_B(rst_b), .WR_EN(wr_en[0]), .RD_EN(rd_en[0]),
        .FLUSH(flush[0]), .CLR_ERR(clr_err[0]), .FIFO_IN(din0), .FIFO_OUT(dout0),
        .FULL(full[0]), .EMPTY(empty[0]), .ALMOST_FULL(af[0]), .ALMOST_EMPTY(ae[0]),
        .COUNT(cnt0), .OVERFLOW(ovf[0]), .UNDERFLOW(unf[0])
    );

    fifo_sync_param #(.WIDTH(8), .DEPTH(5), .AF_TH(4), .AE_TH(2), .CNT_W(3)) u_dut1 (
        .SYSCLK(clk), .RST_B(rst_b), .WR_EN(wr_en[1]), .RD_EN(rd_en[1]),
        .FLUSH(flush[1]), .CLR_ERR(clr_err[1]), .FIFO_IN(din1), .FIFO_OUT(dout1),
        .FULL(full[1]), .EMPTY(empty[1]), .ALMOST_FULL(af[1]), .ALMOST_EMPTY(ae[1]),
        .COUNT(cnt1), .OVERFLOW(ovf[1]), .UNDERFLOW(unf[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: queues hold the words the FIFO should contain.
    logic [W-1:0] sb0[$];
    logic [W-1:0] sb1[$];
    int           m_cnt [2];
    bit           m_ovf [2];
    bit           m_unf [2];

    function automatic int dep(input int s);
        return (s == 0) ? D0 : D1;
    endfunction
    function automatic int af_th(input int s);
        return (s == 0) ? AF0 : AF1;
    endfunction
    function automatic int ae_th(input int s);
        return (s == 0) ? AE0 : AE1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_state(input int s);
        logic [2:0] c;
        c = (s == 0) ? cnt0 : cnt1;
        chk($sformatf("u%0d.count", s), 32'(c), 32'(m_cnt[s]));
        chk($sformatf("u%0d.full", s), 32'(full[s]), 32'(m_cnt[s] == dep(s)));
        chk($sformatf("u%0d.empty", s), 32'(empty[s]), 32'(m_cnt[s] == 0));
        chk($sformatf("u%0d.almost_full", s), 32'(af[s]), 32'(m_cnt[s] >= af_th(s)));
        chk($sformatf("u%0d.almost_empty", s), 32'(ae[s]), 32'(m_cnt[s] <= ae_th(s)));
        chk($sformatf("u%0d.overflow", s), 32'(ovf[s]), 32'(m_ovf[s]));
        chk($sformatf("u%0d.underflow", s), 32'(unf[s]), 32'(m_unf[s]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    // One clock of stimulus on instance s; the other instance idles.
    task automatic cycle(input int s, input bit wr, input bit rd, input bit fl,
                         input bit ce, input logic [W-1:0] d, output bit acc);
        bit rd_ok, wr_ok;
        @(negedge clk);
        wr_en = '0; rd_en = '0; flush = '0; clr_err = '0;
        wr_en[s] = wr; rd_en[s] = rd; flush[s] = fl; clr_err[s] = ce;
        if (s == 0) din0 = d; else din1 = d;
        rd_ok = rd && (m_cnt[s] > 0);
        wr_ok = wr && ((m_cnt[s] < dep(s)) || rd_ok);
        acc = wr_ok && !fl;
        if (fl) begin
            m_cnt[s] = 0;
            if (s == 0) sb0.delete(); else sb1.delete();
            m_ovf[s] = m_ovf[s] && !ce;
            m_unf[s] = m_unf[s] && !ce;
        end else begin
            if (wr_ok) begin
                if (s == 0) sb0.push_back(d); else sb1.push_back(d);
            end
            m_ovf[s] = (m_ovf[s] && !ce) || (wr && !wr_ok);
            m_unf[s] = (m_unf[s] && !ce) || (rd && m_cnt[s] == 0);
            m_cnt[s] = m_cnt[s] + int'(wr_ok) - int'(rd_ok);
        end
        @(posedge clk);
        #1;
        check_state(s);
    endtask

    task automatic async_reset();
        @(negedge clk);
        rst_b = 1'b0;
        wr_en = '0; rd_en = '0; flush = '0; clr_err = '0;
        #1;
        model_reset();
        check_state(0);
        check_state(1);
        chk("u0.fifo_out_rst", 32'(dout0), 32'd0);
        chk("u1.fifo_out_rst", 32'(dout1), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    // Monitor: a read handshake (RD_EN & ~EMPTY) pops the scoreboard; otherwise FIFO_OUT must hold.
    logic [W-1:0] last0 = '0;
    logic [W-1:0] last1 = '0;
    logic [1:0]   fire;

    always begin
        @(posedge clk);
        fire = rd_en & ~empty & ~flush & {2{rst_b}};
        if (!rst_b) begin
            last0 = '0;
            last1 = '0;
        end
        #1;
        if (fire[0]) begin
            if (sb0.size() == 0) begin
                checks++; errors++;
                $display("FAIL u0.sb_underrun actual read-accepted required no-read");
            end else last0 = sb0.pop_front();
        end
        chk("u0.fifo_out", 32'(dout0), 32'(last0));
        if (fire[1]) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1.sb_underrun actual read-accepted required no-read");
            end else last1 = sb1.pop_front();
        end
        chk("u1.fifo_out", 32'(dout1), 32'(last1));
    end

    initial begin
        bit           acc;
        int           written;
        logic [W-1:0] seq [5];
        seq[0] = 8'd11; seq[1] = 8'd24; seq[2] = 8'd31; seq[3] = 8'd46; seq[4] = 8'd57;

        rst_b = 1'b0;
        wr_en = '0; rd_en = '0; flush = '0; clr_err = '0;
        din0 = '0; din1 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state(0);
        check_state(1);
        @(negedge clk);
        rst_b = 1'b1;

        cycle(0, 0, 0, 0, 0, 8'd0, acc);
        // Fill to full, then a dropped fifth write.
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, seq[i], acc);
        // Simultaneous read/write while full.
        cycle(0, 1, 1, 0, 0, 8'd57, acc);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0, 0, 8'd0, acc);
        // Reads on empty: underflow, output held.
        for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0, 8'd0, acc);
        cycle(0, 0, 0, 0, 1, 8'd0, acc);
        // Flush with a concurrent write.
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 8'(i + 1), acc);
        cycle(0, 1, 0, 1, 0, 8'd99, acc);
        cycle(0, 0, 0, 0, 0, 8'd0, acc);

        for (int i = 0; i < 250; i++)
            cycle(0, $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
                  8'($urandom), acc);

        cycle(0, 1, 0, 0, 0, 8'hA5, acc);
        cycle(0, 1, 0, 0, 0, 8'h5A, acc);
        async_reset();
        cycle(0, 0, 0, 0, 0, 8'd0, acc);

        // DEPTH=5: twelve words through with random gaps, then drain.
        written = 0;
        for (int k = 0; k < 400 && (written < 12 || m_cnt[1] > 0); k++) begin
            cycle(1, (written < 12) && ($urandom_range(0, 2) != 0),
                  $urandom_range(0, 1) == 1, 0, 0, 8'(100 + written), acc);
            if (acc) written++;
        end
        chk("u1.words_written", 32'(written), 32'd12);
        cycle(1, 0, 0, 0, 1, 8'd0, acc);

        for (int i = 0; i < 250; i++)
            cycle(1, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                  $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
                  8'($urandom), acc);

        cycle(1, 1, 0, 0, 0, 8'h3C, acc);
        async_reset();
        cycle(1, 0, 0, 0, 0, 8'd0, acc);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
